// File: rtl/uart_frame_ctrl.sv
// Collects operand A, operand B and opcode bytes from the UART receiver into one frame with a valid/ready handshake.
// Define UART_FRAME_TIMEOUT_EN to build the inter-byte timeout counter.
//
// state   | meaning
// WAIT_A  | idle, waiting for operand A
// WAIT_B  | operand A held, waiting for operand B
// WAIT_OP | operands held, waiting for opcode
// PRESENT | frame_valid high until frame_ready
module uart_frame_ctrl #(
  parameter int BITS_PER_DATA = 8,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     rx_done,
  input  logic                     rx_error,
  input  logic [BITS_PER_DATA-1:0] d_in,
  input  logic                     frame_ready,
  output logic [BITS_PER_DATA-1:0] op_a,
  output logic [BITS_PER_DATA-1:0] op_b,
  output logic [BITS_PER_DATA-1:0] op_code,
  output logic                     frame_valid,
  output logic                     frame_error,
  output logic [1:0]               err_cause,
  output logic                     busy
);

  typedef enum logic [1:0] {WAIT_A, WAIT_B, WAIT_OP, PRESENT} state_t;

  state_t                   state_q, state_d;
  logic [BITS_PER_DATA-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_code_q, op_code_d;
  logic                     frame_valid_q, frame_valid_d;
  logic                     frame_error_q, frame_error_d;
  logic [1:0]               err_cause_q, err_cause_d;
  logic                     busy_q, busy_d;
  logic                     timeout_hit;
  logic                     good_byte;

  assign good_byte = rx_done & ~rx_error;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_gap;

  assign in_gap      = (state_q == WAIT_B) || (state_q == WAIT_OP);
  // A byte arriving on the expiring tick takes priority over the abort.
  assign timeout_hit = in_gap && tick && !rx_done && (cnt_q == CNT_W'(TIMEOUT_TICKS - 1));

  always_comb begin
    cnt_d = '0;
    if (in_gap && !rx_done && !timeout_hit) begin
      cnt_d = tick ? cnt_q + CNT_W'(1) : cnt_q;
    end
  end
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= WAIT_A;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_code_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      err_cause_q   <= 2'b00;
      busy_q        <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_code_q     <= op_code_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      err_cause_q   <= err_cause_d;
      busy_q        <= busy_d;
`ifdef UART_FRAME_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_A:  if (rx_done) state_d = rx_error ? WAIT_A : WAIT_B;
      WAIT_B: begin
        if (rx_done)          state_d = rx_error ? WAIT_A : WAIT_OP;
        else if (timeout_hit) state_d = WAIT_A;
      end
      WAIT_OP: begin
        if (rx_done)          state_d = rx_error ? WAIT_A : PRESENT;
        else if (timeout_hit) state_d = WAIT_A;
      end
      PRESENT: if (frame_ready) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  always_comb begin
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_code_d     = op_code_q;
    frame_error_d = 1'b0;
    err_cause_d   = err_cause_q;
    if (state_q == PRESENT && frame_ready) err_cause_d = 2'b00;
    // Errors are applied after the handshake clear so a same-cycle error wins.
    if (rx_done && (state_q == PRESENT || rx_error)) begin
      frame_error_d = 1'b1;
      err_cause_d   = (state_q == PRESENT) ? 2'b11 : 2'b01;
    end
    if (timeout_hit) begin
      frame_error_d = 1'b1;
      err_cause_d   = 2'b10;
    end
    if (good_byte) begin
      unique case (state_q)
        WAIT_A:  op_a_d    = d_in;
        WAIT_B:  op_b_d    = d_in;
        WAIT_OP: op_code_d = d_in;
        default: ;
      endcase
    end
    frame_valid_d = (state_d == PRESENT);
    busy_d        = (state_d != WAIT_A);
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_code     = op_code_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign err_cause   = err_cause_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: fixed vector table, directed corner sequences and
// randomized traffic against a byte-queue reference model.
module tb_uart_frame_ctrl;

  localparam int TIMEOUT_TICKS = 640;
`ifdef UART_FRAME_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, tick, rx_done, rx_error, frame_ready;
  logic [7:0] d_in;
  logic [7:0] op_a, op_b, op_code;
  logic       frame_valid, frame_error, busy;
  logic [1:0] err_cause;

  int checks = 0;
  int errors = 0;

  uart_frame_ctrl #(.BITS_PER_DATA(8), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .rx_done(rx_done), .rx_error(rx_error),
    .d_in(d_in), .frame_ready(frame_ready), .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .frame_valid(frame_valid), .frame_error(frame_error), .err_cause(err_cause), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the partial frame, the held frame and the sticky code.
  logic [7:0] part[$];
  logic [7:0] m_a, m_b, m_c;
  logic       m_present, m_fe, m_busy;
  logic [1:0] m_err;
  int         m_ticks;

  task automatic model_edge(input logic r, rd, re, input logic [7:0] d, input logic fr, tk);
    m_fe = 1'b0;
    if (!r) begin
      part.delete();
      m_a = 0; m_b = 0; m_c = 0; m_present = 0; m_err = 0; m_ticks = 0;
    end else if (m_present) begin
      if (fr) begin m_present = 0; m_err = 0; end
      if (rd) begin m_fe = 1; m_err = 2'd3; end
    end else if (rd) begin
      m_ticks = 0;
      if (re) begin
        part.delete(); m_fe = 1; m_err = 2'd1;
      end else begin
        part.push_back(d);
        case (part.size())
          1: m_a = d;
          2: m_b = d;
          default: begin m_c = d; m_present = 1; part.delete(); end
        endcase
      end
    end else if (TO_EN && tk && part.size() > 0) begin
      m_ticks++;
      if (m_ticks == TIMEOUT_TICKS) begin
        m_fe = 1; m_err = 2'd2; part.delete(); m_ticks = 0;
      end
    end
    m_busy = m_present || (part.size() > 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("op_a", op_a, m_a);
    chk("op_b", op_b, m_b);
    chk("op_code", op_code, m_c);
    chk("frame_valid", frame_valid, m_present);
    chk("frame_error", frame_error, m_fe);
    chk("err_cause", err_cause, m_err);
    chk("busy", busy, m_busy);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare at the falling edge.
  task automatic step(input logic r, rd, re, input logic [7:0] d, input logic fr, tk);
    reset = r; rx_done = rd; rx_error = re; d_in = d; frame_ready = fr; tick = tk;
    @(posedge clk);
    model_edge(r, rd, re, d, fr, tk);
    @(negedge clk);
    chk_model();
  endtask

  typedef struct packed {
    logic rst, rd, re; logic [7:0] d; logic fr;
    logic [7:0] ea, eb, ec; logic efv, efe; logic [1:0] eerr; logic ebusy;
  } vec_t;

  vec_t vecs[25];

  initial begin
    vecs[0]  = '{0,0,0,8'h00,0, 8'h00,8'h00,8'h00,0,0,2'd0,0};
    vecs[1]  = '{1,1,0,8'h12,0, 8'h12,8'h00,8'h00,0,0,2'd0,1};
    vecs[2]  = '{1,0,0,8'h00,0, 8'h12,8'h00,8'h00,0,0,2'd0,1};
    vecs[3]  = '{1,1,0,8'h34,0, 8'h12,8'h34,8'h00,0,0,2'd0,1};
    vecs[4]  = '{1,1,0,8'h20,0, 8'h12,8'h34,8'h20,1,0,2'd0,1};
    vecs[5]  = '{1,0,0,8'h00,1, 8'h12,8'h34,8'h20,0,0,2'd0,0};
    vecs[6]  = '{1,1,0,8'h05,0, 8'h05,8'h34,8'h20,0,0,2'd0,1};
    vecs[7]  = '{1,1,1,8'hFF,0, 8'h05,8'h34,8'h20,0,1,2'd1,0};
    vecs[8]  = '{1,0,0,8'h00,0, 8'h05,8'h34,8'h20,0,0,2'd1,0};
    vecs[9]  = '{1,1,0,8'hAA,0, 8'hAA,8'h34,8'h20,0,0,2'd1,1};
    vecs[10] = '{1,1,0,8'hBB,0, 8'hAA,8'hBB,8'h20,0,0,2'd1,1};
    vecs[11] = '{1,1,0,8'h01,0, 8'hAA,8'hBB,8'h01,1,0,2'd1,1};
    vecs[12] = '{1,0,0,8'h00,1, 8'hAA,8'hBB,8'h01,0,0,2'd0,0};
    vecs[13] = '{1,1,0,8'h01,0, 8'h01,8'hBB,8'h01,0,0,2'd0,1};
    vecs[14] = '{1,1,0,8'h02,0, 8'h01,8'h02,8'h01,0,0,2'd0,1};
    vecs[15] = '{1,1,0,8'h03,0, 8'h01,8'h02,8'h03,1,0,2'd0,1};
    vecs[16] = '{1,1,0,8'h44,0, 8'h01,8'h02,8'h03,1,1,2'd3,1};
    vecs[17] = '{1,0,0,8'h00,0, 8'h01,8'h02,8'h03,1,0,2'd3,1};
    vecs[18] = '{1,0,0,8'h00,1, 8'h01,8'h02,8'h03,0,0,2'd0,0};
    vecs[19] = '{1,1,0,8'h07,0, 8'h07,8'h02,8'h03,0,0,2'd0,1};
    vecs[20] = '{1,1,0,8'h08,0, 8'h07,8'h08,8'h03,0,0,2'd0,1};
    vecs[21] = '{1,1,0,8'h09,0, 8'h07,8'h08,8'h09,1,0,2'd0,1};
    vecs[22] = '{1,1,1,8'h55,1, 8'h07,8'h08,8'h09,0,1,2'd3,0};
    vecs[23] = '{1,0,0,8'h00,0, 8'h07,8'h08,8'h09,0,0,2'd3,0};
    vecs[24] = '{1,0,0,8'h00,1, 8'h07,8'h08,8'h09,0,0,2'd3,0};

    reset = 0; tick = 0; rx_done = 0; rx_error = 0; d_in = 0; frame_ready = 0;
    part.delete();
    m_a = 0; m_b = 0; m_c = 0; m_present = 0; m_fe = 0; m_err = 0; m_busy = 0; m_ticks = 0;
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      reset = vecs[i].rst; rx_done = vecs[i].rd; rx_error = vecs[i].re;
      d_in = vecs[i].d; frame_ready = vecs[i].fr; tick = 1'b0;
      @(posedge clk);
      model_edge(vecs[i].rst, vecs[i].rd, vecs[i].re, vecs[i].d, vecs[i].fr, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d.op_a", i), op_a, vecs[i].ea);
      chk($sformatf("v%0d.op_b", i), op_b, vecs[i].eb);
      chk($sformatf("v%0d.op_code", i), op_code, vecs[i].ec);
      chk($sformatf("v%0d.frame_valid", i), frame_valid, vecs[i].efv);
      chk($sformatf("v%0d.frame_error", i), frame_error, vecs[i].efe);
      chk($sformatf("v%0d.err_cause", i), err_cause, vecs[i].eerr);
      chk($sformatf("v%0d.busy", i), busy, vecs[i].ebusy);
    end

    // Inter-byte gap behaviour.
    step(0, 0, 0, 8'h00, 0, 0);
    step(1, 1, 0, 8'h10, 0, 0);
    for (int i = 0; i < TIMEOUT_TICKS - 1; i++) step(1, 0, 0, 8'h00, 0, 1);
    chk("gap.busy_before_last_tick", busy, 1'b1);
    step(1, 0, 0, 8'h00, 0, 1);
    if (TO_EN) begin
      chk("to.frame_error", frame_error, 1'b1);
      chk("to.err_cause", err_cause, 2'd2);
      chk("to.busy", busy, 1'b0);
      step(1, 1, 0, 8'h10, 0, 0);
      for (int i = 0; i < TIMEOUT_TICKS - 1; i++) step(1, 0, 0, 8'h00, 0, 1);
      step(1, 1, 0, 8'h11, 0, 1);
      chk("to_race.frame_error", frame_error, 1'b0);
      chk("to_race.op_b", op_b, 8'h11);
      chk("to_race.busy", busy, 1'b1);
      for (int i = 0; i < TIMEOUT_TICKS - 1; i++) step(1, 0, 0, 8'h00, 0, 1);
      chk("to_restart.busy", busy, 1'b1);
      step(1, 1, 0, 8'h12, 0, 0);
      chk("to_restart.frame_valid", frame_valid, 1'b1);
      step(1, 0, 0, 8'h00, 1, 0);
    end else begin
      chk("no_to.frame_error", frame_error, 1'b0);
      chk("no_to.busy", busy, 1'b1);
      for (int i = 0; i < 60; i++) step(1, 0, 0, 8'h00, 0, 1);
      chk("no_to.err_cause", err_cause, 2'd0);
      step(1, 1, 0, 8'h11, 0, 0);
      step(1, 1, 0, 8'h12, 0, 0);
      chk("no_to.frame_valid", frame_valid, 1'b1);
      step(1, 0, 0, 8'h00, 1, 0);
    end

    // Reset mid-frame and mid-PRESENT, with a byte in the reset cycle.
    step(1, 1, 0, 8'h21, 0, 0);
    step(1, 1, 0, 8'h22, 0, 0);
    step(0, 1, 0, 8'h33, 0, 0);
    chk("rst_op.op_a", op_a, 8'h00);
    chk("rst_op.busy", busy, 1'b0);
    step(1, 1, 0, 8'h01, 0, 0);
    step(1, 1, 0, 8'h02, 0, 0);
    step(1, 1, 1, 8'h03, 0, 0);
    step(1, 1, 0, 8'h01, 0, 0);
    step(1, 1, 0, 8'h02, 0, 0);
    step(1, 1, 0, 8'h03, 0, 0);
    chk("pre_rst.frame_valid", frame_valid, 1'b1);
    step(0, 1, 0, 8'h77, 1, 0);
    chk("rst_pr.frame_valid", frame_valid, 1'b0);
    chk("rst_pr.op_code", op_code, 8'h00);
    chk("rst_pr.err_cause", err_cause, 2'd0);
    step(1, 1, 0, 8'h61, 0, 0);
    step(1, 1, 0, 8'h62, 0, 0);
    step(1, 1, 0, 8'h63, 0, 0);
    chk("post_rst.op_a", op_a, 8'h61);
    chk("post_rst.op_code", op_code, 8'h63);
    step(1, 0, 0, 8'h00, 1, 0);

    // Random traffic: busy byte stream, then sparse bytes so gaps can expire.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(299, 0) != 0, $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0,
           8'($urandom), $urandom_range(2, 0) == 0, $urandom_range(1, 0) == 0);
    for (int i = 0; i < 6000; i++)
      step($urandom_range(4999, 0) != 0, $urandom_range(499, 0) == 0, $urandom_range(7, 0) == 0,
           8'($urandom), $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Frame sequencer behind the UART receiver: collects three consecutive received bytes (operand A, operand B, opcode) into one command frame and presents it to the downstream ALU/consumer over a valid/ready handshake. Receiver error pulses, overruns and (optionally) inter-byte timeouts abort a partial frame and are reported on a sticky status code. Sits between the receiver's `d_out`/`rx_done`/`error` outputs and the execution datapath; shares the receiver's baud `tick`.

## Interface
- `BITS_PER_DATA`, 8, width of each received byte and of every frame field
- `TIMEOUT_TICKS`, 640, tick pulses allowed between bytes of one frame (4 frame times at 16 ticks/bit); counter width = clog2(TIMEOUT_TICKS)

- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-low; sampled on rising `clk`
- `tick`  in  1  baud oversample strobe, one `clk` wide
- `rx_done`  in  1  receiver byte-complete strobe, one `clk` wide
- `rx_error`  in  1  receiver parity error, qualified by `rx_done`
- `d_in`  in  BITS_PER_DATA  received byte, valid when `rx_done`=1
- `frame_ready`  in  1  consumer accepts frame
- `op_a`  out  BITS_PER_DATA  first byte of frame
- `op_b`  out  BITS_PER_DATA  second byte
- `op_code`  out  BITS_PER_DATA  third byte
- `frame_valid`  out  1  frame held stable while high
- `frame_error`  out  1  one-cycle pulse per aborted frame/dropped byte
- `err_cause`  out  2  sticky: 00 none, 01 parity, 10 timeout, 11 overrun
- `busy`  out  1  high whenever state is not WAIT_A

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, PRESENT.
- Good byte = `rx_done`=1 and `rx_error`=0.
- WAIT_A: good byte -> latch `op_a`, go WAIT_B. WAIT_B: good byte -> latch `op_b`, go WAIT_OP. WAIT_OP: good byte -> latch `op_code`, go PRESENT.
- `rx_done`=1 with `rx_error`=1 in WAIT_A/B/OP: byte discarded, partial frame abandoned, `frame_error` pulse, `err_cause`=01, go WAIT_A.
- PRESENT: `frame_valid`=1; `op_a`/`op_b`/`op_code` unchanged. `frame_ready`=1 -> go WAIT_A, `frame_valid` low next cycle.
- `rx_done` in PRESENT (any `rx_error`, including the same cycle as `frame_ready`): byte dropped, `frame_error` pulse, `err_cause`=11; the held frame is still delivered normally.
- `err_cause` holds its last value until the next frame handshake (`frame_valid`&`frame_ready`), which clears it to 00 in the same edge, or until reset. A simultaneous new error in the handshake cycle wins (code written, not cleared).
- Field registers keep their old values when not loaded; only `frame_valid` qualifies them.

## Timing
- Reset (`reset`=0 at an edge): state WAIT_A; `op_a`, `op_b`, `op_code`=0; `frame_valid`=0; `frame_error`=0; `err_cause`=00; `busy`=0; timeout counter=0. Applies mid-frame and mid-PRESENT; an `rx_done` in the reset cycle is ignored.
- All outputs are registered. Latency: `rx_done` of the third byte at edge N -> `frame_valid`=1 after edge N.
- `frame_error` is high for exactly the one cycle following the offending edge.
- Back-to-back: a good byte may arrive in the first WAIT_A cycle after the handshake.

## Configuration
- `UART_FRAME_TIMEOUT_EN` defined: the counter clears on every accepted byte and on entry to WAIT_A. It advances on `tick` only in WAIT_B and WAIT_OP. On a `tick` with count = TIMEOUT_TICKS-1: `frame_error` pulse, `err_cause`=10, go WAIT_A. If `rx_done` occurs in the same cycle, the byte wins: it is processed normally and the counter clears.
- Not defined: no counter is built. A partial frame waits indefinitely, code 10 is never produced, and `tick` is ignored.

## Test plan
- Bytes 0x12, 0x34, 0x20 (good), `frame_ready`=1 on the first valid cycle -> `op_a`=0x12, `op_b`=0x34, `op_code`=0x20, `frame_valid` high exactly one cycle, `err_cause`=00, `busy` back to 0.
- 0x05 good, then a byte with `rx_error`=1 -> one `frame_error` pulse, `err_cause`=01, state WAIT_A. Then 0xAA, 0xBB, 0x01 -> frame delivered and `err_cause` cleared after the handshake.
- Frame 0x01, 0x02, 0x03 with `frame_ready` held 0; extra byte 0x44 arrives -> `frame_error` pulse, `err_cause`=11, outputs still 0x01/0x02/0x03. Raise `frame_ready` -> frame accepted, 0x44 never appears.
- Macro on, TIMEOUT_TICKS=640: byte 0x10, then 640 ticks with no `rx_done` -> abort on the 640th tick, `err_cause`=10. Repeat with a byte arriving on the 640th tick -> accepted, no error.
- `reset`=0 for one edge while in WAIT_OP and again while in PRESENT -> all outputs at their reset values next cycle. A following full 3-byte frame is delivered correctly.
